// File: rtl/tanh_pkg.sv
// Shared constants and types for the tanh datapath: operand format,
// bit-slice code format and the rounding shift between them.
package tanh_pkg;

  localparam int IN_W      = 16;
  localparam int FRAC_W    = 12;
  localparam int CODE_W    = 6;
  localparam int CODE_FRAC = 4;
  localparam int SH        = FRAC_W - CODE_FRAC;

  typedef logic [CODE_W-1:0]      tanh_code_t;
  typedef logic signed [IN_W-1:0] tanh_operand_t;

endpackage

// File: rtl/tanh_pipe_reg.sv
// Generic elastic register slice.
// Handshake: a beat moves across an interface on a rising edge where
// valid and ready are both high. valid never depends on ready. The slice
// takes a new beat whenever it is empty or its own beat is leaving, so
// ready_o is combinational from ready_i.
module tanh_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Load a new beat when advancing; payload only changes when a beat arrives.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  // Slice state; payload clears to zero so outputs read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/tanh_operand_quantizer.sv
// Operand front-end for the tanh bit slices: splits a signed fixed-point
// operand into sign and magnitude (S1), then rounds half-up and saturates
// the magnitude to the 6-bit slice code (S2). Counts saturated transfers.
module tanh_operand_quantizer #(
  parameter int IN_W      = tanh_pkg::IN_W,
  parameter int FRAC_W    = tanh_pkg::FRAC_W,
  parameter int CODE_W    = tanh_pkg::CODE_W,
  parameter int CODE_FRAC = tanh_pkg::CODE_FRAC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_sign,
  output logic              out_sat,
  input  logic              sat_clr,
  output logic [15:0]       sat_count
);

  localparam int SH  = FRAC_W - CODE_FRAC;
  // Width of the rounded magnitude: the (IN_W+1)-bit sum shifted down by SH.
  localparam int R_W = IN_W + 1 - SH;
  localparam logic [R_W-1:0]  R_MAX = R_W'((2 ** CODE_W) - 1);
  localparam logic [IN_W:0]   HALF  = (IN_W + 1)'(1) << (SH - 1);
  localparam int S2_W = CODE_W + 2;

  // S1 input: magnitude is IN_W bits wide so the most negative operand
  // maps to 2^(IN_W-1) without wrapping.
  logic              in_sign;
  logic [IN_W-1:0]   in_mag;
  assign in_sign = in_data[IN_W-1];
  assign in_mag  = in_sign ? (~in_data + 1'b1) : in_data;

  logic              s1_valid, s2_in_ready;
  logic [IN_W:0]     s1_data;

  tanh_pipe_reg #(.W(IN_W + 1)) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_i  ({in_sign, in_mag}),
    .valid_o (s1_valid),
    .ready_i (s2_in_ready),
    .data_o  (s1_data)
  );

  // S2 input: round half-up, saturate, suppress negative zero.
  logic              s1_sign;
  logic [IN_W-1:0]   s1_mag;
  logic [IN_W:0]     sum;
  logic [R_W-1:0]    r;
  logic              rnd_sat;
  logic [CODE_W-1:0] rnd_code;
  logic              rnd_sign;

  assign s1_sign  = s1_data[IN_W];
  assign s1_mag   = s1_data[IN_W-1:0];
  assign sum      = {1'b0, s1_mag} + HALF;
  assign r        = R_W'(sum >> SH);
  assign rnd_sat  = r > R_MAX;
  assign rnd_code = rnd_sat ? '1 : r[CODE_W-1:0];
  assign rnd_sign = s1_sign && (rnd_code != '0);

  logic [S2_W-1:0]   s2_data;

  tanh_pipe_reg #(.W(S2_W)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (s1_valid),
    .ready_o (s2_in_ready),
    .data_i  ({rnd_sign, rnd_code, rnd_sat}),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (s2_data)
  );

  assign out_sign = s2_data[S2_W-1];
  assign out_code = s2_data[CODE_W:1];
  assign out_sat  = s2_data[0];

  // Saturation counter: clear wins over increment, holds at all-ones.
  logic [15:0] sat_count_q, sat_count_d;

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (out_valid && out_ready && out_sat && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count_q <= '0;
    else        sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_tanh_operand_quantizer.sv
// Bench for tanh_operand_quantizer: directed steps plus a random stream,
// with a negedge monitor scoring every output transfer against a model.
module tb_tanh_operand_quantizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_code;
  logic        out_sign;
  logic        out_sat;
  logic        sat_clr = 1'b0;
  logic [15:0] sat_count;

  tanh_operand_quantizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_sign  (out_sign),
    .out_sat   (out_sat),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  // Clock and counters
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int n_out  = 0;

  // Scoreboard: {sign, code, sat} per accepted operand
  logic [7:0]  exp_q[$];
  logic [15:0] exp_cnt = '0;
  logic        hold_v = 1'b0;
  logic [7:0]  hold_d = '0;
  logic [7:0]  mon_o;

  function automatic logic [7:0] model(input logic [15:0] d);
    int v, mag, r;
    logic s, sat;
    logic [5:0] code;
    v    = int'($signed(d));
    mag  = (v < 0) ? -v : v;
    r    = (mag + 128) / 256;
    sat  = (r > 63);
    code = sat ? 6'd63 : r[5:0];
    s    = (v < 0) && (code != 6'd0);
    return {s, code, sat};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: transfers are decided by values stable at the negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_o = {out_sign, out_code, out_sat};
      if (hold_v) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hold", {24'd0, mon_o}, {24'd0, hold_d});
      end
      chk("sat_count", {16'd0, sat_count}, {16'd0, exp_cnt});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("out_when_empty", {31'd0, out_valid}, 32'd0);
        else begin
          chk("out", {24'd0, mon_o}, {24'd0, exp_q.pop_front()});
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
      if (sat_clr) exp_cnt = '0;
      else if (out_valid && out_ready && out_sat && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      hold_v = out_valid && !out_ready;
      hold_d = mon_o;
    end
  end

  // Driver: hold one operand until accepted; returns at posedge+1.
  task automatic send(input logic [15:0] d);
    int budget;
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    acc      = 1'b0;
    budget   = 0;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // Send into an empty pipe and check the two-stage latency and the code.
  task automatic send_lat(input logic [15:0] d, input logic [5:0] code,
                          input logic sign, input logic sat);
    send(d);
    @(negedge clk);
    chk("lat_s1_empty", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_s2_valid", {31'd0, out_valid}, 32'd1);
    chk("code", {26'd0, out_code}, {26'd0, code});
    chk("sign", {31'd0, out_sign}, {31'd0, sign});
    chk("sat", {31'd0, out_sat}, {31'd0, sat});
    @(posedge clk); #1;
  endtask

  logic [15:0] bp_ops[5] = '{16'h0100, 16'h8000, 16'h0080, 16'hFE80, 16'h3F7F};
  logic [15:0] edges[8]  = '{16'h7F7F, 16'h3F7F, 16'h3F80, 16'h8000,
                             16'h7FFF, 16'hFF90, 16'h0080, 16'hFF80};

  initial begin
    int idx, acc_n, cyc, base;
    logic got;

    // Reset values
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_code", {26'd0, out_code}, 32'd0);
    chk("rst_out_sign", {31'd0, out_sign}, 32'd0);
    chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
    chk("rst_sat_count", {16'd0, sat_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Rounding
    send_lat(16'h0100, 6'd1, 1'b0, 1'b0);
    send_lat(16'h007F, 6'd0, 1'b0, 1'b0);
    send_lat(16'h0080, 6'd1, 1'b0, 1'b0);
    send_lat(16'hFE80, 6'd2, 1'b1, 1'b0);

    // Negative zero and extremes
    send_lat(16'hFF90, 6'd0, 1'b0, 1'b0);
    send_lat(16'h8000, 6'd63, 1'b1, 1'b1);
    send_lat(16'h7FFF, 6'd63, 1'b0, 1'b1);
    chk("sat_count_2", {16'd0, sat_count}, 32'd2);

    // Saturation boundary
    send_lat(16'h7F7F, 6'd63, 1'b0, 1'b1);
    send_lat(16'h3F7F, 6'd63, 1'b0, 1'b0);
    send_lat(16'h3F80, 6'd63, 1'b0, 1'b1);
    chk("sat_count_4", {16'd0, sat_count}, 32'd4);

    // Backpressure: 6 stalled cycles with a 5-operand burst offered
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = bp_ops[idx];
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 5);
      in_data  = bp_ops[(idx < 5) ? idx : 4];
      @(negedge clk);
      chk("bp_back_to_back", {31'd0, out_valid}, 32'd1);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", idx, 5);

    // Clear alone
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("clr_alone", {16'd0, sat_count}, 32'd0);

    // Preload the counter to all-ones, then one more saturated transfer
    in_valid = 1'b1;
    in_data  = 16'h7FFF;
    acc_n = 0;
    cyc = 0;
    while (acc_n < 65535 && cyc < 70000) begin
      @(negedge clk);
      if (in_ready) acc_n++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("preload_accepts", acc_n, 65535);
    repeat (4) @(posedge clk);
    #1;
    chk("preload_full", {16'd0, sat_count}, 32'h0000FFFF);
    send_lat(16'h7FFF, 6'd63, 1'b0, 1'b1);
    chk("count_holds", {16'd0, sat_count}, 32'h0000FFFF);

    // Reset with two operands in flight
    out_ready = 1'b0;
    send(16'h0100);
    send(16'h8000);
    #3 rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    hold_v  = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sat_count", {16'd0, sat_count}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_stale_out", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    send_lat(16'h0200, 6'd2, 1'b0, 1'b0);

    // Clear coincident with a saturated transfer
    send_lat(16'h7FFF, 6'd63, 1'b0, 1'b1);
    chk("count_one", {16'd0, sat_count}, 32'd1);
    send(16'h8000);
    @(posedge clk); #1;
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("clr_priority", {16'd0, sat_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Random stream
    base  = n_out;
    acc_n = 0;
    cyc   = 0;
    while (acc_n < 10000 && cyc < 40000) begin
      if (!in_valid) begin
        in_valid = ($urandom_range(0, 9) != 0);
        in_data  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 7)] : 16'($urandom);
      end
      out_ready = ($urandom_range(0, 9) != 0);
      got = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc_n++;
        got = 1'b1;
      end
      @(posedge clk); #1;
      if (got) in_valid = 1'b0;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand_accepts", acc_n, 10000);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", {31'd0, out_valid}, 32'd0);
    chk("rand_outputs", n_out - base, acc_n);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
